// File: rtl/de0_timer_pkg.sv
// Shared register map and bit positions for the DE0 multi-channel interval timer.
package de0_timer_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam int unsigned BIT_TO    = 0;
  localparam int unsigned BIT_RUN   = 1;
  localparam int unsigned BIT_ITO   = 0;
  localparam int unsigned BIT_CONT  = 1;
  localparam int unsigned BIT_START = 2;
  localparam int unsigned BIT_STOP  = 3;
  localparam int unsigned DIV_LSB   = 8;

endpackage

// File: rtl/de0_timer_channel.sv
// One timer channel: prescaler, down-counter with PERIOD reload, snapshot and IRQ.
module de0_timer_channel
  import de0_timer_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PS_W         = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h84
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_status,
  input  logic        wr_control,
  input  logic        wr_period,
  input  logic        wr_snap,
  input  logic [31:0] writedata,
  output logic [31:0] status_rd,
  output logic [31:0] control_rd,
  output logic [31:0] period_rd,
  output logic [31:0] snap_rd,
  output logic        irq
);

  localparam int unsigned PS_WI = (PS_W > 0) ? PS_W : 1;
  localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] count, period, snap;
  logic [PS_WI-1:0] ps_cnt, div_q, div_d;
  logic             ito, cont, to, run, reload_pend;
  logic             tick, timeout, start, stop;

  // The new DIV is used on the START edge so the first tick already honours it.
  always_comb begin
    div_d = div_q;
    if (PS_W > 0 && wr_control) div_d = writedata[DIV_LSB +: PS_WI];
    tick    = run && (ps_cnt == '0);
    timeout = tick && (count == '0);
    start   = wr_control && writedata[BIT_START];
    stop    = wr_control && writedata[BIT_STOP];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_cnt <= '0;
    end else if (!run || reload_pend || ps_cnt == '0) begin
      ps_cnt <= div_d;
    end else begin
      ps_cnt <= ps_cnt - PS_WI'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= RST_CNT;
      period      <= RST_CNT;
      snap        <= '0;
      div_q       <= '0;
      ito         <= 1'b0;
      cont        <= 1'b0;
      to          <= 1'b0;
      run         <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      if (wr_control) begin
        ito   <= writedata[BIT_ITO];
        cont  <= writedata[BIT_CONT];
        div_q <= div_d;
      end
      if (wr_period) period <= writedata[CNT_W-1:0];
      reload_pend <= wr_period;
      if (reload_pend) begin
        count <= period;
      end else if (tick) begin
        count <= timeout ? period : count - CNT_W'(1);
      end
      if (wr_snap) snap <= count;
      // Setting TO beats a simultaneous software clear so no event is lost.
      if (timeout) begin
        to <= 1'b1;
      end else if (wr_status && writedata[BIT_TO]) begin
        to <= 1'b0;
      end
      if (start) begin
        run <= 1'b1;
      end else if (stop || wr_period || (timeout && !cont)) begin
        run <= 1'b0;
      end
    end
  end

  always_comb begin
    status_rd          = '0;
    status_rd[BIT_TO]  = to;
    status_rd[BIT_RUN] = run;
    control_rd           = '0;
    control_rd[BIT_ITO]  = ito;
    control_rd[BIT_CONT] = cont;
    if (PS_W > 0) control_rd[DIV_LSB +: PS_WI] = div_q;
    period_rd              = '0;
    period_rd[CNT_W-1:0]   = period;
    snap_rd                = '0;
    snap_rd[CNT_W-1:0]     = snap;
  end

  assign irq = to && ito;

endmodule

// File: rtl/de0_multi_timer.sv
// Avalon-MM multi-channel interval timer: address decode, registered read mux, IRQ OR.
module de0_multi_timer
  import de0_timer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PS_W         = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h84
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [$clog2(NUM_CH)+1:0]    address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic                         read_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic [NUM_CH-1:0]            irq,
  output logic                         irq_any
);

  localparam int unsigned AW   = $clog2(NUM_CH) + 2;
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]                ch_idx;
  logic [NUM_CH-1:0]              wr_status, wr_control, wr_period, wr_snap;
  logic [NUM_CH-1:0][3:0][31:0]   rd_word;
  logic [31:0]                    rd_mux;
  logic                           bus_wr;

  generate
    if (NUM_CH > 1) begin : g_multi
      assign ch_idx = address[AW-1:2];
    end else begin : g_single
      assign ch_idx = '0;
    end
  endgenerate

  // Channel indices >= NUM_CH match no channel: reads give 0, writes go nowhere.
  always_comb begin
    bus_wr     = chipselect && !write_n;
    wr_status  = '0;
    wr_control = '0;
    wr_period  = '0;
    wr_snap    = '0;
    rd_mux     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_W'(i)) begin
        wr_status[i]  = bus_wr && (address[1:0] == REG_STATUS);
        wr_control[i] = bus_wr && (address[1:0] == REG_CONTROL);
        wr_period[i]  = bus_wr && (address[1:0] == REG_PERIOD);
        wr_snap[i]    = bus_wr && (address[1:0] == REG_SNAP);
        rd_mux        = rd_word[i][address[1:0]];
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      de0_timer_channel #(
        .CNT_W        (CNT_W),
        .PS_W         (PS_W),
        .RESET_PERIOD (RESET_PERIOD)
      ) u_channel (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_status  (wr_status[i]),
        .wr_control (wr_control[i]),
        .wr_period  (wr_period[i]),
        .wr_snap    (wr_snap[i]),
        .writedata  (writedata),
        .status_rd  (rd_word[i][REG_STATUS]),
        .control_rd (rd_word[i][REG_CONTROL]),
        .period_rd  (rd_word[i][REG_PERIOD]),
        .snap_rd    (rd_word[i][REG_SNAP]),
        .irq        (irq[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (chipselect && !read_n) begin
      readdata <= rd_mux;
    end
  end

  assign irq_any = |irq;

endmodule
